maquina_de_cafe: RTL and testbench



---
 rtl/maquina_de_cafe_pkg.sv | 40 ++++
 rtl/maquina_de_cafe.sv | 66 ++++++
 tb/tb_maquina_de_cafe.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/maquina_de_cafe_pkg.sv
// Shared definitions for the coffee/tea dispenser controller.
// Holds the 4-bit state encoding, the 3-bit action codes driven on `out`,
// and helpers that classify terminal states and map them to their codes.
package maquina_de_cafe_pkg;

    typedef enum logic [3:0] {
        ESPERA         = 4'b0000,
        MONEDA         = 4'b0001,
        AGUA           = 4'b0010,
        TE             = 4'b0011,
        CAFE           = 4'b0100,
        SERVIR_CAFE    = 4'b0110,
        DEVOLVER       = 4'b0111,
        SERVIR_TE      = 4'b1000,
        SERVIR_TE_DEV5 = 4'b1001
    } estado_t;

    // Action codes. Prefixed because CAFE/TE/DEVOLVER are also state names.
    localparam logic [2:0] OUT_NADA       = 3'b000;
    localparam logic [2:0] OUT_CAFE       = 3'b001;
    localparam logic [2:0] OUT_TE         = 3'b010;
    localparam logic [2:0] OUT_DEVOLVER   = 3'b100;
    localparam logic [2:0] OUT_DEVOLVER_5 = 3'b101;

    function automatic logic es_terminal(input logic [3:0] e);
        return (e == SERVIR_CAFE) || (e == DEVOLVER) ||
               (e == SERVIR_TE)   || (e == SERVIR_TE_DEV5);
    endfunction

    function automatic logic [2:0] codigo_de(input logic [3:0] e);
        case (e)
            SERVIR_CAFE:    return OUT_CAFE;
            DEVOLVER:       return OUT_DEVOLVER;
            SERVIR_TE:      return OUT_TE;
            SERVIR_TE_DEV5: return OUT_DEVOLVER_5;
            default:        return OUT_NADA;
        endcase
    endfunction

endpackage

// File: rtl/maquina_de_cafe.sv
// Control FSM for a coin-operated coffee/tea dispenser.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   hm   - coin present          ha - water available
//   bp   - selection button      bc - coffee button   bt - tea button
//   hc   - coffee stock present  md - coin is 10      mc - coin is 5
//   out  - 3-bit action code for the dispenser/coin-return mechanics
module maquina_de_cafe
    import maquina_de_cafe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hm,
    input  logic       ha,
    input  logic       bp,
    input  logic       bc,
    input  logic       bt,
    input  logic       hc,
    input  logic       md,
    input  logic       mc,
    output logic [2:0] out
);

    estado_t estado, estado_sig;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) estado <= ESPERA;
        else      estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            ESPERA: if (hm) estado_sig = MONEDA;
            MONEDA: if (ha) estado_sig = AGUA;
            AGUA: begin
                // Tea is checked first so it wins when both buttons are held.
                if (bp && bt)            estado_sig = TE;
                else if (bp && bc && hc) estado_sig = CAFE;
                else if (bp && bc)       estado_sig = DEVOLVER;
            end
            TE: begin
                if (md)      estado_sig = SERVIR_TE_DEV5;
                else if (mc) estado_sig = SERVIR_TE;
            end
            CAFE: begin
                if (md)      estado_sig = SERVIR_CAFE;
                else if (mc) estado_sig = DEVOLVER;
            end
            // Terminal states and unused encodings all fall back to ESPERA.
            default: estado_sig = ESPERA;
        endcase
    end

    // Lookahead output: a terminal next state drives its code in the same
    // cycle the deciding input is seen; the code is held while in that state.
    always_comb begin
        out = OUT_NADA;
        if (rst) begin
            if (es_terminal(estado_sig))  out = codigo_de(estado_sig);
            else if (es_terminal(estado)) out = codigo_de(estado);
        end
    end

endmodule

// File: tb/tb_maquina_de_cafe.sv
module tb_maquina_de_cafe;

    logic       clk;
    logic       rst;
    logic       hm, ha, bp, bc, bt, hc, md, mc;
    logic [2:0] out;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [2:0]  esperado_q[$];

    // Input vector bit positions: {hm,ha,bp,bc,bt,hc,md,mc}
    localparam logic [7:0] I_HM = 8'b1000_0000;
    localparam logic [7:0] I_HA = 8'b0100_0000;
    localparam logic [7:0] I_BP = 8'b0010_0000;
    localparam logic [7:0] I_BC = 8'b0001_0000;
    localparam logic [7:0] I_BT = 8'b0000_1000;
    localparam logic [7:0] I_HC = 8'b0000_0100;
    localparam logic [7:0] I_MD = 8'b0000_0010;
    localparam logic [7:0] I_MC = 8'b0000_0001;
    localparam logic [7:0] I_NO = 8'b0000_0000;

    maquina_de_cafe dut (
        .clk (clk),
        .rst (rst),
        .hm  (hm),
        .ha  (ha),
        .bp  (bp),
        .bc  (bc),
        .bt  (bt),
        .hc  (hc),
        .md  (md),
        .mc  (mc),
        .out (out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: out=%b expected=%b at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic esperar(input logic [2:0] exp);
        esperado_q.push_back(exp);
    endtask

    task automatic comparar(input string tag);
        logic [2:0] exp;
        if (esperado_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, out=%b", tag, out);
        end else begin
            exp = esperado_q.pop_front();
            check(tag, out, exp);
        end
    endtask

    task automatic poner(input logic [7:0] v);
        {hm, ha, bp, bc, bt, hc, md, mc} = v;
    endtask

    // One full cycle: drive at negedge, check before the rising edge, then clock.
    task automatic ciclo(input string tag, input logic [7:0] v, input logic [2:0] exp);
        @(negedge clk);
        poner(v);
        esperar(exp);
        #5;
        comparar(tag);
        @(posedge clk);
    endtask

    task automatic ir_a_agua();
        ciclo("esp_hm", I_HM, 3'b000);
        ciclo("mon_ha", I_HA, 3'b000);
    endtask

    initial begin
        rst = 1'b0;
        poner(I_NO);
        #3;
        esperar(3'b000); comparar("in_reset");
        poner(I_HM | I_HA | I_MD);
        #2;
        esperar(3'b000); comparar("in_reset_inputs");
        poner(I_NO);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);

        for (int i = 0; i < 5; i++) ciclo("idle", I_NO, 3'b000);

        // Tea paid with 10: pulse md mid-cycle without an edge.
        ir_a_agua();
        ciclo("agua_tea_sel", I_BP | I_BT, 3'b000);
        @(negedge clk);
        poner(I_NO);
        esperar(3'b000); #2; comparar("te_wait");
        md = 1'b1;
        esperar(3'b101); #2; comparar("te_md_pulse");
        md = 1'b0;
        esperar(3'b000); #2; comparar("te_md_drop");
        @(posedge clk);
        ciclo("te_still", I_NO, 3'b000);
        ciclo("te_md_held", I_MD, 3'b101);
        ciclo("te_dev5_state", I_NO, 3'b101);
        ciclo("te_dev5_back", I_NO, 3'b000);

        // Coffee paid with 10; hm ignored outside ESPERA, bc ignored while bp=0.
        ciclo("esp_hm", I_HM, 3'b000);
        ciclo("mon_no_water", I_HM, 3'b000);
        ciclo("mon_ha", I_HA, 3'b000);
        ciclo("agua_no_bp", I_BC | I_HC | I_BT, 3'b000);
        ciclo("agua_cafe_sel", I_BP | I_BC | I_HC, 3'b000);
        ciclo("cafe_wait", I_NO, 3'b000);
        ciclo("cafe_md_mc", I_MD | I_MC, 3'b001);
        ciclo("cafe_serve_state", I_NO, 3'b001);
        ciclo("cafe_back", I_NO, 3'b000);

        // Coffee paid with 5: insufficient, full return.
        ir_a_agua();
        ciclo("agua_cafe_sel2", I_BP | I_BC | I_HC, 3'b000);
        ciclo("cafe_mc", I_MC, 3'b100);
        ciclo("cafe_dev_state", I_NO, 3'b100);
        ciclo("cafe_dev_back", I_NO, 3'b000);

        // Coffee with no stock: return decided in the selection cycle.
        ir_a_agua();
        ciclo("agua_no_stock", I_BP | I_BC, 3'b100);
        ciclo("no_stock_state", I_NO, 3'b100);
        ciclo("no_stock_back", I_NO, 3'b000);

        // Both buttons pressed, no coffee stock: tea wins, no return.
        ir_a_agua();
        ciclo("agua_both", I_BP | I_BC | I_BT, 3'b000);
        ciclo("te_after_both", I_NO, 3'b000);
        ciclo("te_md_over_mc", I_MD | I_MC, 3'b101);
        ciclo("te_dev5_state2", I_NO, 3'b101);
        ciclo("back2", I_NO, 3'b000);

        // Tea paid with 5.
        ir_a_agua();
        ciclo("agua_tea_sel3", I_BP | I_BT, 3'b000);
        ciclo("te_mc", I_MC, 3'b010);
        ciclo("te_serve_state", I_NO, 3'b010);
        ciclo("te_serve_back", I_NO, 3'b000);

        // Asynchronous reset pulse while in TE, between clock edges.
        ir_a_agua();
        ciclo("agua_tea_sel4", I_BP | I_BT, 3'b000);
        @(negedge clk);
        poner(I_MD);
        esperar(3'b101); #2; comparar("te_before_rst");
        rst = 1'b0;
        esperar(3'b000); #1; comparar("async_rst_out");
        rst = 1'b1;
        esperar(3'b000); #2; comparar("after_rst_espera");
        @(posedge clk);
        ciclo("after_rst_md", I_MD, 3'b000);
        ciclo("after_rst_idle", I_NO, 3'b000);

        if (esperado_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: entries=%0d expected=0", esperado_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
